// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// TX FSM state encoding and the STATUS word layout.
package mmio_uart_tx_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int BYTE_W    = 8;

  localparam logic [3:0] UART_TXDATA_OFS  = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS  = 4'h4;
  localparam logic [3:0] UART_TXCOUNT_OFS = 4'h8;

  localparam int STATUS_OVF_BIT = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [BIT_WIDTH-1:0] pack_status(
    input logic [7:0] fifo_count,
    input logic       overflow,
    input logic       busy,
    input logic       empty,
    input logic       full
  );
    logic [BIT_WIDTH-1:0] s;
    s       = '0;
    s[0]    = full;
    s[1]    = empty;
    s[2]    = busy;
    s[3]    = overflow;
    s[15:8] = fifo_count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is still accepted when a pop
// happens on the same edge. Output data is the head entry, read asynchronously.
module uart_fifo
  import mmio_uart_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file, byte FIFO,
// TX FSM with baud counter and a wrapping count of fully sent bytes.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                 InputClk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] AddressBus,
  input  logic [BIT_WIDTH-1:0] DataBusOut,
  input  logic [2:0]           ControlBus,
  output logic [BIT_WIDTH-1:0] BusRdata,
  output logic                 BusHit,
  output logic                 uart_tx,
  output logic                 tx_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic       sel, rd_en, wr_en;
  logic [3:0] ofs;
  logic       wr_txdata, wr_status, wr_txcount;

  logic              fifo_pop;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;

  tx_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    txcount_q, txcount_d;
  logic           boundary, frame_done, ovf_set;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{ControlBus[0], DataBusOut[31:8]};

  always_comb begin
    sel        = (AddressBus[31:4] == BASE_ADDR[31:4]);
    rd_en      = ControlBus[1];
    wr_en      = ControlBus[2];
    ofs        = AddressBus[3:0];
    wr_txdata  = sel && wr_en && (ofs == UART_TXDATA_OFS);
    wr_status  = sel && wr_en && (ofs == UART_STATUS_OFS);
    wr_txcount = sel && wr_en && (ofs == UART_TXCOUNT_OFS);
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (InputClk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (DataBusOut[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The FSM only sees the registered FIFO state, so a push into an empty FIFO
  // is picked up one edge later (no bypass path).
  always_comb begin
    boundary   = (cnt_q == CNT_LAST);
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    cnt_d      = (state_q == TX_IDLE || boundary) ? '0 : cnt_q + 1'b1;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = TX_START;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (boundary) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      TX_DATA: begin
        if (boundary) begin
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_d[0];
          end
        end
      end
      TX_STOP: begin
        if (boundary) begin
          frame_done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Clear beats increment on TXCOUNT; set beats clear on overflow.
  always_comb begin
    ovf_set   = wr_txdata && fifo_full && !fifo_pop;
    ovf_d     = ovf_q;
    txcount_d = txcount_q;
    if (wr_status && DataBusOut[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (ovf_set)                                 ovf_d = 1'b1;
    if (frame_done)                              txcount_d = txcount_q + 1'b1;
    if (wr_txcount)                              txcount_d = '0;
  end

  always_ff @(posedge InputClk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      txcount_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      txcount_q <= txcount_d;
    end
  end

  always_comb begin
    BusHit   = sel && rd_en;
    BusRdata = '0;
    if (sel) begin
      case (ofs)
        UART_STATUS_OFS:  BusRdata = pack_status(8'(fifo_count), ovf_q,
                                                 state_q != TX_IDLE,
                                                 fifo_empty, fifo_full);
        UART_TXCOUNT_OFS: BusRdata = txcount_q;
        default:          BusRdata = '0;
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign tx_idle = fifo_empty && (state_q == TX_IDLE);

endmodule
